// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path.
// Holds the unit class encodings and the width of one queued entry.
// An entry holds a 2-bit class, a carry bit and a 2*WIDTH data word.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_CLS_ARITH = 2'd0,
    ALU_CLS_LOGIC = 2'd1,
    ALU_CLS_CMP   = 2'd2,
    ALU_CLS_SHIFT = 2'd3
  } alu_cls_e;

  localparam int ALU_WIDTH = 16;
  localparam int ENTRY_W   = 2*ALU_WIDTH+3;

  // Entry width for a non-default operand width.
  function automatic int entry_width(input int width);
    return 2*width+3;
  endfunction

endpackage

// File: rtl/alu_result_queue_if.sv
// Bundle of signals between the ALU, the result queue and its consumer.
//   master : the ALU side plus the consumer. It drives the results, flags,
//            OUT_READY and CLR_ERR.
//   slave  : the queue. It drives the head entry, COUNT and the sticky
//            error bits.
interface alu_result_queue_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  logic                        RES_VALID;
  logic signed [2*WIDTH-1:0]   ARITH_OUT;
  logic                        CARRY_OUT;
  logic                        ARITH_FLAG;
  logic                        LOGIC_FLAG;
  logic                        CMP_FLAG;
  logic                        SHIFT_FLAG;
  logic signed [WIDTH-1:0]     LOGIC_OUT;
  logic signed [WIDTH-1:0]     CMP_OUT;
  logic signed [WIDTH-1:0]     SHIFT_OUT;
  logic                        OUT_VALID;
  logic                        OUT_READY;
  logic [1:0]                  OUT_CLASS;
  logic signed [2*WIDTH-1:0]   OUT_DATA;
  logic                        OUT_CARRY;
  logic [$clog2(DEPTH):0]      COUNT;
  logic                        ERR_FLAGS;
  logic                        ERR_OVF;
  logic                        CLR_ERR;

  modport master (
    output RES_VALID, ARITH_OUT, CARRY_OUT, ARITH_FLAG, LOGIC_FLAG, CMP_FLAG,
           SHIFT_FLAG, LOGIC_OUT, CMP_OUT, SHIFT_OUT, OUT_READY, CLR_ERR,
    input  OUT_VALID, OUT_CLASS, OUT_DATA, OUT_CARRY, COUNT, ERR_FLAGS, ERR_OVF
  );

  modport slave (
    input  RES_VALID, ARITH_OUT, CARRY_OUT, ARITH_FLAG, LOGIC_FLAG, CMP_FLAG,
           SHIFT_FLAG, LOGIC_OUT, CMP_OUT, SHIFT_OUT, OUT_READY, CLR_ERR,
    output OUT_VALID, OUT_CLASS, OUT_DATA, OUT_CARRY, COUNT, ERR_FLAGS, ERR_OVF
  );
endinterface

// File: rtl/alu_flag_encoder.sv
// Combinational encoder for the ALU unit-active flags.
//   *_flag_i     : unit-active flags
//   cls_o        : encoded unit class, which is ARITH when the flags are not one-hot
//   one_hot_ok_o : exactly one flag is high
module alu_flag_encoder
  import alu_pkg::*;
(
  input  logic     arith_flag_i,
  input  logic     logic_flag_i,
  input  logic     cmp_flag_i,
  input  logic     shift_flag_i,
  output alu_cls_e cls_o,
  output logic     one_hot_ok_o
);

  always_comb begin
    cls_o        = ALU_CLS_ARITH;
    one_hot_ok_o = 1'b0;
    case ({shift_flag_i, cmp_flag_i, logic_flag_i, arith_flag_i})
      4'b0001: begin cls_o = ALU_CLS_ARITH; one_hot_ok_o = 1'b1; end
      4'b0010: begin cls_o = ALU_CLS_LOGIC; one_hot_ok_o = 1'b1; end
      4'b0100: begin cls_o = ALU_CLS_CMP;   one_hot_ok_o = 1'b1; end
      4'b1000: begin cls_o = ALU_CLS_SHIFT; one_hot_ok_o = 1'b1; end
      default: begin cls_o = ALU_CLS_ARITH; one_hot_ok_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/alu_result_queue.sv
// Captures the active ALU unit's result and tags it with its class. The
// result is buffered in a DEPTH-entry FIFO and drained over valid/ready.
// The ALU cannot be stalled. Bad flag patterns and pushes dropped while
// the FIFO is full therefore set sticky error bits.
//   CLK : clock
//   RST : asynchronous active-low reset
//   bus : slave side of alu_result_queue_if
//         (ALU results and flags in; head entry, COUNT and errors out)
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  alu_result_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = 2*WIDTH;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    alu_cls_e             cls;
    logic                 carry;
    logic signed [DW-1:0] data;
  } entry_t;

  function automatic logic signed [DW-1:0] sext(input logic signed [WIDTH-1:0] v);
    return {{WIDTH{v[WIDTH-1]}}, v};
  endfunction

  alu_cls_e    cls;
  logic        one_hot_ok;
  entry_t      new_entry;
  entry_t      head;
  entry_t      mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic        err_flags_q, err_flags_d, err_ovf_q, err_ovf_d;
  logic        empty, full, push, pop, flag_evt, ovf_evt;

  alu_flag_encoder u_enc (
    .arith_flag_i (bus.ARITH_FLAG),
    .logic_flag_i (bus.LOGIC_FLAG),
    .cmp_flag_i   (bus.CMP_FLAG),
    .shift_flag_i (bus.SHIFT_FLAG),
    .cls_o        (cls),
    .one_hot_ok_o (one_hot_ok)
  );

  always_comb begin
    new_entry       = '0;
    new_entry.cls   = cls;
    new_entry.carry = 1'b0;
    case (cls)
      ALU_CLS_ARITH: begin
        new_entry.data  = bus.ARITH_OUT;
        new_entry.carry = bus.CARRY_OUT;
      end
      ALU_CLS_LOGIC: new_entry.data = sext(bus.LOGIC_OUT);
      ALU_CLS_CMP:   new_entry.data = sext(bus.CMP_OUT);
      default:       new_entry.data = sext(bus.SHIFT_OUT);
    endcase
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  // The pop decision uses only registered occupancy, not the push, so a
  // push into an empty FIFO cannot fall through in the same cycle.
  assign pop      = bus.OUT_READY && !empty;
  assign push     = bus.RES_VALID && one_hot_ok && (!full || pop);
  assign flag_evt = bus.RES_VALID && !one_hot_ok;
  assign ovf_evt  = bus.RES_VALID && one_hot_ok && full && !pop;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A new error event takes priority over a clear in the same cycle.
    err_flags_d = flag_evt ? 1'b1 : (bus.CLR_ERR ? 1'b0 : err_flags_q);
    err_ovf_d   = ovf_evt  ? 1'b1 : (bus.CLR_ERR ? 1'b0 : err_ovf_q);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_flags_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_flags_q <= err_flags_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // Storage is not reset. Stale contents stay invisible because the
  // outputs are masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.OUT_VALID = !empty;
  assign bus.OUT_CLASS = empty ? 2'd0 : head.cls;
  assign bus.OUT_DATA  = empty ? '0 : head.data;
  assign bus.OUT_CARRY = empty ? 1'b0 : head.carry;
  assign bus.COUNT     = count_q;
  assign bus.ERR_FLAGS = err_flags_q;
  assign bus.ERR_OVF   = err_ovf_q;

endmodule

// File: tb/tb_alu_result_queue.sv
module tb_alu_result_queue;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   errs = 0;
  int   checks = 0;

  alu_result_queue_if #(.WIDTH(16), .DEPTH(4)) bus ();

  alu_result_queue #(.WIDTH(16), .DEPTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.RES_VALID  = 1'b0;
    bus.ARITH_FLAG = 1'b0;
    bus.LOGIC_FLAG = 1'b0;
    bus.CMP_FLAG   = 1'b0;
    bus.SHIFT_FLAG = 1'b0;
    bus.ARITH_OUT  = '0;
    bus.CARRY_OUT  = 1'b0;
    bus.LOGIC_OUT  = '0;
    bus.CMP_OUT    = '0;
    bus.SHIFT_OUT  = '0;
    bus.OUT_READY  = 1'b0;
    bus.CLR_ERR    = 1'b0;
  endtask

  // Drive one result of the given class. The caller steps the clock.
  task automatic set_res(input int cls, input logic [31:0] v, input logic c);
    bus.RES_VALID  = 1'b1;
    bus.ARITH_FLAG = (cls == 0);
    bus.LOGIC_FLAG = (cls == 1);
    bus.CMP_FLAG   = (cls == 2);
    bus.SHIFT_FLAG = (cls == 3);
    bus.ARITH_OUT  = v;
    bus.LOGIC_OUT  = v[15:0];
    bus.CMP_OUT    = v[15:0];
    bus.SHIFT_OUT  = v[15:0];
    bus.CARRY_OUT  = c;
  endtask

  task automatic push_cyc(input int cls, input logic [31:0] v, input logic c);
    set_res(cls, v, c);
    step();
    idle();
  endtask

  task automatic pop_cyc();
    bus.OUT_READY = 1'b1;
    step();
    bus.OUT_READY = 1'b0;
  endtask

  initial begin
    logic [31:0] drain_exp [4];
    drain_exp[0] = 32'd2; drain_exp[1] = 32'd3;
    drain_exp[2] = 32'd4; drain_exp[3] = 32'd6;
    idle();
    #3;
    chk("rst_count", bus.COUNT, 0);
    chk("rst_valid", bus.OUT_VALID, 0);
    chk("rst_data", $unsigned(bus.OUT_DATA), 0);
    chk("rst_class", bus.OUT_CLASS, 0);
    chk("rst_carry", bus.OUT_CARRY, 0);
    chk("rst_errf", bus.ERR_FLAGS, 0);
    chk("rst_erro", bus.ERR_OVF, 0);
    step();
    RST = 1'b1;

    // Arith -4 + -5 = -9, with carry out set
    push_cyc(0, 32'hFFFFFFF7, 1'b1);
    chk("ar_valid", bus.OUT_VALID, 1);
    chk("ar_class", bus.OUT_CLASS, 0);
    chk("ar_data", $unsigned(bus.OUT_DATA), 32'hFFFFFFF7);
    chk("ar_carry", bus.OUT_CARRY, 1);
    chk("ar_count", bus.COUNT, 1);
    pop_cyc();
    chk("ar_pop_count", bus.COUNT, 0);
    chk("ar_pop_valid", bus.OUT_VALID, 0);
    chk("ar_pop_data", $unsigned(bus.OUT_DATA), 0);

    // OUT_READY while empty is ignored
    pop_cyc();
    chk("empty_rdy_count", bus.COUNT, 0);

    // cmp, then logic (carry ignored for logic), then shift
    push_cyc(2, 32'h0000FFFE, 1'b1);
    push_cyc(1, 32'h0000000D, 1'b1);
    push_cyc(3, 32'h00008000, 1'b0);
    chk("ord_count", bus.COUNT, 3);
    chk("ord0_class", bus.OUT_CLASS, 2);
    chk("ord0_data", $unsigned(bus.OUT_DATA), 32'hFFFFFFFE);
    chk("ord0_carry", bus.OUT_CARRY, 0);
    pop_cyc();
    chk("ord1_class", bus.OUT_CLASS, 1);
    chk("ord1_data", $unsigned(bus.OUT_DATA), 32'h0000000D);
    chk("ord1_carry", bus.OUT_CARRY, 0);
    pop_cyc();
    chk("ord2_class", bus.OUT_CLASS, 3);
    chk("ord2_data", $unsigned(bus.OUT_DATA), 32'hFFFF8000);
    pop_cyc();
    chk("ord_empty", bus.OUT_VALID, 0);

    // Fill past capacity with the consumer stalled
    for (int i = 1; i <= 5; i++) push_cyc(0, 32'(i), 1'b0);
    chk("ovf_count", bus.COUNT, 4);
    chk("ovf_err", bus.ERR_OVF, 1);
    chk("ovf_errf", bus.ERR_FLAGS, 0);
    chk("ovf_head", $unsigned(bus.OUT_DATA), 1);
    bus.CLR_ERR = 1'b1;
    step();
    bus.CLR_ERR = 1'b0;
    chk("ovf_clr", bus.ERR_OVF, 0);
    chk("ovf_hold_head", $unsigned(bus.OUT_DATA), 1);

    // Full with a simultaneous push and pop
    set_res(0, 32'd6, 1'b0);
    bus.OUT_READY = 1'b1;
    step();
    idle();
    chk("fpp_err", bus.ERR_OVF, 0);
    chk("fpp_count", bus.COUNT, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), $unsigned(bus.OUT_DATA), drain_exp[i]);
      pop_cyc();
    end
    chk("drain_count", bus.COUNT, 0);

    // Flag errors
    set_res(0, 32'd7, 1'b0);
    bus.CMP_FLAG = 1'b1;
    step();
    idle();
    chk("ferr2_set", bus.ERR_FLAGS, 1);
    chk("ferr2_nopush", bus.COUNT, 0);
    bus.CLR_ERR = 1'b1;
    step();
    bus.CLR_ERR = 1'b0;
    chk("ferr_clr", bus.ERR_FLAGS, 0);
    set_res(0, 32'd7, 1'b0);
    bus.ARITH_FLAG = 1'b0;
    step();
    idle();
    chk("ferr0_set", bus.ERR_FLAGS, 1);
    chk("ferr0_nopush", bus.COUNT, 0);
    set_res(0, 32'd7, 1'b0);
    bus.ARITH_FLAG = 1'b0;
    bus.CLR_ERR = 1'b1;
    step();
    idle();
    chk("ferr_set_wins", bus.ERR_FLAGS, 1);
    bus.CLR_ERR = 1'b1;
    step();
    bus.CLR_ERR = 1'b0;
    chk("ferr_clr2", bus.ERR_FLAGS, 0);

    // RES_VALID low: bad flags are ignored
    bus.ARITH_FLAG = 1'b1;
    bus.CMP_FLAG   = 1'b1;
    step();
    idle();
    chk("novalid_errf", bus.ERR_FLAGS, 0);
    chk("novalid_count", bus.COUNT, 0);

    // Asynchronous reset with entries queued
    push_cyc(0, 32'd11, 1'b0);
    push_cyc(1, 32'd12, 1'b0);
    push_cyc(2, 32'd13, 1'b0);
    chk("pre_rst_count", bus.COUNT, 3);
    #2;
    RST = 1'b0;
    #1;
    chk("arst_count", bus.COUNT, 0);
    chk("arst_valid", bus.OUT_VALID, 0);
    chk("arst_data", $unsigned(bus.OUT_DATA), 0);
    step();
    RST = 1'b1;
    push_cyc(0, 32'd9, 1'b0);
    chk("post_rst_count", bus.COUNT, 1);
    chk("post_rst_data", $unsigned(bus.OUT_DATA), 9);
    pop_cyc();
    chk("post_rst_empty", bus.COUNT, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Downstream stage of the signed ALU top: captures the registered result of whichever ALU unit is flagged active, tags it with its unit class, and buffers it in a small FIFO. A consumer drains it over a valid/ready handshake. Malformed flag patterns and overflow are reported through sticky error bits instead of stalling the ALU, which has no back-pressure.

## Interface
- WIDTH, 16, ALU operand width; arithmetic result is 2*WIDTH.
- DEPTH, 4, FIFO entries; power of two, at least 2.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous active-low reset.
- RES_VALID  in  1  ALU outputs hold a new result this cycle; driven by issue logic, aligned with the ALU's registered outputs.
- ARITH_OUT  in  2*WIDTH  signed arithmetic result.
- CARRY_OUT  in  1  arithmetic carry.
- ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG  in  1 each  ALU unit-active flags.
- LOGIC_OUT, CMP_OUT, SHIFT_OUT  in  WIDTH each  signed unit results.
- OUT_VALID  out  1  head entry available.
- OUT_READY  in  1  consumer accepts the head entry.
- OUT_CLASS  out  2  unit class: 0 arith, 1 logic, 2 cmp, 3 shift.
- OUT_DATA  out  2*WIDTH  result; WIDTH-wide units sign-extended.
- OUT_CARRY  out  1  CARRY_OUT for arith entries, 0 otherwise.
- COUNT  out  log2(DEPTH)+1  occupancy.
- ERR_FLAGS  out  1  sticky: RES_VALID seen with flags not one-hot.
- ERR_OVF  out  1  sticky: push dropped because the FIFO was full.
- CLR_ERR  in  1  synchronous clear of both sticky bits.

## Operation
- Push condition: RES_VALID high, exactly one flag high, and the FIFO is not full or a pop happens in the same cycle.
- Entry captured on push: the class is the encoded flag.
  - Data is ARITH_OUT when class is 0.
  - Otherwise data is the selected WIDTH-bit output, sign-extended to 2*WIDTH.
  - Carry is CARRY_OUT when class is 0, otherwise 0.
- Flag error: RES_VALID with zero or more than one flag high.
  - No push.
  - ERR_FLAGS is set.
- Overflow: RES_VALID with one-hot flags, the FIFO full, and no pop in the same cycle.
  - Entry is dropped and ERR_OVF is set.
  - Contents are unchanged.
- Full with simultaneous pop: the push succeeds, COUNT stays at DEPTH, and there is no error.
- Pop occurs when OUT_VALID and OUT_READY are both high.
  - Read pointer advances.
  - OUT_READY while empty is ignored.
- Simultaneous push and pop when empty: not possible. The pushed entry becomes visible the next cycle (no fall-through).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- COUNT update per cycle: +1 on push only, −1 on pop only, unchanged on both or neither.
- CLR_ERR versus set: a set event in the same cycle wins over CLR_ERR.
- RES_VALID low: flags and data are ignored, and there is no error check.

## Timing
- Reset (asynchronous, RST low) clears:
  - both pointers, COUNT=0, OUT_VALID=0;
  - ERR_FLAGS=0, ERR_OVF=0;
  - OUT_CLASS=0, OUT_DATA=0, OUT_CARRY=0 (outputs are masked to 0 while empty).
- Reset mid-operation discards all entries immediately. The first push after release is accepted on the first rising edge with RST high.
- Latency: a push at edge N gives OUT_VALID and the entry on outputs after edge N; the consumer can pop at edge N+1.
- Throughput: one push and one pop per cycle, sustained.
- OUT_* fields are held stable while OUT_VALID is high and OUT_READY is low.
- COUNT, ERR_* and OUT_VALID are registered or derived from registered state only; none has a combinational path from RES_VALID or OUT_READY.

## Structure
- Shared package alu_pkg holds:
  - class encodings ALU_CLS_ARITH=0, ALU_CLS_LOGIC=1, ALU_CLS_CMP=2, ALU_CLS_SHIFT=3;
  - the entry record width constant ENTRY_W = 2*WIDTH+3.
- Sub-module alu_flag_encoder: combinational. Maps the four flags to the 2-bit class plus a one_hot_ok bit.
- Storage: DEPTH x ENTRY_W register array, no memory macro.

## Test plan
- Reset, then push arith −4+−5 (ARITH_OUT=−9, ARITH_FLAG=1):
  - one cycle later OUT_VALID=1, OUT_CLASS=0, OUT_DATA=32'hFFFFFFF7, COUNT=1;
  - pop, then COUNT=0 and OUT_VALID=0.
- Push CMP_OUT=16'hFFFE (CMP_FLAG) then LOGIC_OUT=16'h000D (LOGIC_FLAG):
  - pops in order give class 2 with data 32'hFFFFFFFE, then class 1 with data 32'h0000000D.
- Hold OUT_READY=0 and push 5 entries (values 1..5):
  - COUNT=4 and ERR_OVF=1;
  - draining returns 1, 2, 3, 4.
- With the FIFO full, push and pop in the same cycle: ERR_OVF stays 0, COUNT stays 4, and the new value appears last.
- RES_VALID with ARITH_FLAG and CMP_FLAG both high, and again with no flag high:
  - no push and ERR_FLAGS=1 both times;
  - CLR_ERR clears it;
  - CLR_ERR in the same cycle as a new error leaves it set.
- Assert RST low with 3 entries queued: COUNT=0, OUT_VALID=0 and OUT_DATA=0 immediately, without waiting for a clock edge.
